// File: rtl/calculator_core.sv
// Unsigned 16-bit arithmetic engine for the VGA calculator display stage.
// Add/sub finish in one cycle; multiply (shift-add) and divide (restoring) take 16 cycles.
module calculator_core #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] DIV0_VAL = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [1:0]       op,
    input  logic             go,
    input  logic             clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             flag,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_c;
    logic               r_flag;
    logic               r_busy;
    logic               r_done;
    logic [CW-1:0]      r_cnt;

    // Iteration state: multiplicand shifts left, multiplier shifts right.
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    // Dividend shifts out MSB first through r_quo while quotient bits shift in.
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_dvsr;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH+1:0]   w_rem_sh;
    logic [WIDTH+1:0]   w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quo_nxt;

    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff    = r_a - r_b;
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_rem_sh - {2'b00, r_dvsr};
    assign w_ge      = ~w_trial[WIDTH+1];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_flag   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
        end else if (clear) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_flag   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Loads land alongside go, but go computes on the pre-edge A/B.
                    if (load_a) r_a <= sw;
                    if (load_b) r_b <= sw;
                    if (go) begin
                        case (op)
                            2'd0: begin
                                r_c    <= w_sum[WIDTH-1:0];
                                r_flag <= w_sum[WIDTH];
                                r_done <= 1'b1;
                            end
                            2'd1: begin
                                r_c    <= w_diff;
                                r_flag <= (r_b > r_a);
                                r_done <= 1'b1;
                            end
                            2'd2: begin
                                r_mcand  <= {{WIDTH{1'b0}}, r_a};
                                r_mplier <= r_b;
                                r_acc    <= '0;
                                r_cnt    <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= S_MUL;
                            end
                            default: begin
                                if (r_b == '0) begin
                                    r_c    <= DIV0_VAL;
                                    r_flag <= 1'b1;
                                    r_done <= 1'b1;
                                end else begin
                                    r_quo   <= r_a;
                                    r_dvsr  <= r_b;
                                    r_rem   <= '0;
                                    r_cnt   <= '0;
                                    r_busy  <= 1'b1;
                                    r_state <= S_DIV;
                                end
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_c     <= w_acc_nxt[WIDTH-1:0];
                        r_flag  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_trial[WIDTH:0] : w_rem_sh[WIDTH:0];
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_c     <= w_quo_nxt;
                        r_flag  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign A    = r_a;
    assign B    = r_b;
    assign C    = r_c;
    assign flag = r_flag;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_calculator_core.sv
// Directed self-checking bench for calculator_core: arithmetic results, iteration
// timing, busy-window input dropping, synchronous clear and asynchronous reset.
module tb_calculator_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw = '0;
    logic        load_a = 1'b0;
    logic        load_b = 1'b0;
    logic [1:0]  op = '0;
    logic        go = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] A, B, C;
    logic        flag, busy, done;

    int total = 0;
    int bad   = 0;

    calculator_core #(.WIDTH(16), .DIV0_VAL(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .sw(sw), .load_a(load_a), .load_b(load_b),
        .op(op), .go(go), .clear(clear),
        .A(A), .B(B), .C(C), .flag(flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
        sw = a; load_a = 1'b1; tick(); load_a = 1'b0;
        sw = b; load_b = 1'b1; tick(); load_b = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] o);
        op = o; go = 1'b1; tick(); go = 1'b0;
    endtask

    // Ticks until done (bounded); optionally pokes load_a/go mid-iteration.
    task automatic wait_done(input bit inject, output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (inject && i == 5) begin
                sw = 16'h1234; load_a = 1'b1; op = 2'd0; go = 1'b1;
            end
            tick();
            load_a = 1'b0; go = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #3;
        total++;
        if ({A, B, C, flag, busy, done} !== 51'd0) begin
            bad++;
            $display("FAIL reset_state: A=%h B=%h C=%h flag=%b busy=%b done=%b want all 0", A, B, C, flag, busy, done);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_add;
        load_ab(16'h0005, 16'h0003);
        start_op(2'd0);
        total++;
        if ({C, flag, done, busy} !== {16'h0008, 1'b1 ^ 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL add_5_3: C=%h flag=%b done=%b busy=%b want C=0008 flag=0 done=1 busy=0", C, flag, done, busy);
        end
        tick();
        total++;
        if ({done, busy, C} !== {1'b0, 1'b0, 16'h0008}) begin
            bad++;
            $display("FAIL add_done_one_cycle: done=%b busy=%b C=%h want done=0 busy=0 C=0008", done, busy, C);
        end
        load_ab(16'hFFFF, 16'h0001);
        start_op(2'd0);
        total++;
        if ({C, flag, done} !== {16'h0000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL add_carry: C=%h flag=%b done=%b want C=0000 flag=1 done=1", C, flag, done);
        end
    endtask

    task automatic test_sub;
        load_ab(16'h0003, 16'h0005);
        total++;
        if ({C, flag} !== {16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL load_keeps_result: C=%h flag=%b want C=0000 flag=1", C, flag);
        end
        start_op(2'd1);
        total++;
        if ({C, flag, done} !== {16'hFFFE, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sub_borrow: C=%h flag=%b done=%b want C=FFFE flag=1 done=1", C, flag, done);
        end
        load_ab(16'h0005, 16'h0003);
        start_op(2'd1);
        total++;
        if ({C, flag} !== {16'h0002, 1'b0}) begin
            bad++;
            $display("FAIL sub_no_borrow: C=%h flag=%b want C=0002 flag=0", C, flag);
        end
    endtask

    task automatic test_dual_load;
        sw = 16'h0042; load_a = 1'b1; load_b = 1'b1; tick();
        load_a = 1'b0; load_b = 1'b0;
        start_op(2'd0);
        total++;
        if ({A, B, C, flag} !== {16'h0042, 16'h0042, 16'h0084, 1'b0}) begin
            bad++;
            $display("FAIL dual_load_add: A=%h B=%h C=%h flag=%b want A=0042 B=0042 C=0084 flag=0", A, B, C, flag);
        end
    endtask

    task automatic test_mul;
        int cyc;
        bit bok;
        load_ab(16'h0100, 16'h0100);
        start_op(2'd2);
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL mul_start: busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(1'b0, cyc, bok);
        total++;
        if (cyc != 16 || !bok) begin
            bad++;
            $display("FAIL mul_latency: done after %0d edges busy_ok=%b want 16 and 1", cyc, bok);
        end
        total++;
        if ({C, flag, busy} !== {16'h0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mul_overflow: C=%h flag=%b busy=%b want C=0000 flag=1 busy=0", C, flag, busy);
        end
        load_ab(16'h00FF, 16'h0002);
        start_op(2'd2);
        wait_done(1'b1, cyc, bok);
        total++;
        if (cyc != 16 || !bok) begin
            bad++;
            $display("FAIL mul_busy_drop_latency: done after %0d edges busy_ok=%b want 16 and 1", cyc, bok);
        end
        total++;
        if ({C, flag, A} !== {16'h01FE, 1'b0, 16'h00FF}) begin
            bad++;
            $display("FAIL mul_result_hold_a: C=%h flag=%b A=%h want C=01FE flag=0 A=00FF", C, flag, A);
        end
    endtask

    task automatic test_div;
        int cyc;
        bit bok;
        load_ab(16'h0064, 16'h0007);
        start_op(2'd3);
        wait_done(1'b0, cyc, bok);
        total++;
        if (cyc != 16 || !bok) begin
            bad++;
            $display("FAIL div_latency: done after %0d edges busy_ok=%b want 16 and 1", cyc, bok);
        end
        total++;
        if ({C, flag} !== {16'h000E, 1'b0}) begin
            bad++;
            $display("FAIL div_100_7: C=%h flag=%b want C=000E flag=0", C, flag);
        end
        load_ab(16'hFFFF, 16'h0001);
        start_op(2'd3);
        wait_done(1'b0, cyc, bok);
        total++;
        if ({C, flag} !== {16'hFFFF, 1'b0} || cyc != 16) begin
            bad++;
            $display("FAIL div_ffff_1: C=%h flag=%b cyc=%0d want C=FFFF flag=0 cyc=16", C, flag, cyc);
        end
        load_ab(16'hABCD, 16'h1234);
        start_op(2'd3);
        wait_done(1'b0, cyc, bok);
        total++;
        if ({C, flag} !== {16'h0009, 1'b0}) begin
            bad++;
            $display("FAIL div_abcd_1234: C=%h flag=%b want C=0009 flag=0", C, flag);
        end
    endtask

    task automatic test_div0;
        load_ab(16'h0064, 16'h0000);
        start_op(2'd3);
        total++;
        if ({C, flag, done, busy} !== {16'hFFFF, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL div_by_zero: C=%h flag=%b done=%b busy=%b want C=FFFF flag=1 done=1 busy=0", C, flag, done, busy);
        end
        tick();
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL div_by_zero_after: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_clear;
        bit seen;
        load_ab(16'h0003, 16'h0004);
        start_op(2'd2);
        repeat (7) tick();
        clear = 1'b1; tick(); clear = 1'b0;
        total++;
        if ({A, B, C, flag, busy, done} !== 51'd0) begin
            bad++;
            $display("FAIL clear_state: A=%h B=%h C=%h flag=%b busy=%b done=%b want all 0", A, B, C, flag, busy, done);
        end
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL clear_abort: done/busy seen=%b after clear want 0", seen);
        end
        load_ab(16'h0002, 16'h0003);
        start_op(2'd0);
        total++;
        if ({C, flag, done} !== {16'h0005, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL clear_then_add: C=%h flag=%b done=%b want C=0005 flag=0 done=1", C, flag, done);
        end
    endtask

    task automatic test_async_reset;
        load_ab(16'h0064, 16'h0007);
        start_op(2'd3);
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({A, B, C, flag, busy, done} !== 51'd0) begin
            bad++;
            $display("FAIL async_reset: A=%h B=%h C=%h flag=%b busy=%b done=%b want all 0", A, B, C, flag, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        sw = 16'h00AA; load_a = 1'b1; op = 2'd0; go = 1'b1;
        tick();
        load_a = 1'b0; go = 1'b0;
        total++;
        if ({A, B, C, flag, done} !== {16'h00AA, 16'h0000, 16'h0000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL load_go_same_cycle: A=%h B=%h C=%h flag=%b done=%b want A=00AA B=0000 C=0000 flag=0 done=1", A, B, C, flag, done);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_end: done=%b want 0", done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_dual_load();
        test_mul();
        test_div();
        test_div0();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
